// File: rtl/complex_mag_pkg.sv
// Shared widths and FSM encoding for the complex magnitude square-root stage.
package complex_mag_pkg;

  localparam int unsigned CMAG_SQ_W  = 48;
  localparam int unsigned CMAG_MAG_W = 24;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StHold = 2'd2
  } sqrt_state_t;

endpackage

// File: rtl/complex_mag_sqrt_stream_if.sv
// Valid/ready stream bundle: radicand in, root/remainder/last out.
interface complex_mag_sqrt_stream_if
  import complex_mag_pkg::*;
#(
  parameter int unsigned IN_W = CMAG_SQ_W
);
  localparam int unsigned OUT_W = IN_W / 2;

  logic [IN_W-1:0]  s_data;
  logic             s_last;
  logic             s_valid;
  logic             s_ready;
  logic [OUT_W-1:0] m_data;
  logic [OUT_W:0]   m_rem;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;

  modport slave (
    input  s_data, s_last, s_valid, m_ready,
    output s_ready, m_data, m_rem, m_last, m_valid
  );

  modport master (
    output s_data, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_rem, m_last, m_valid
  );

endinterface

// File: rtl/complex_mag_sqrt_step.sv
// One restoring square-root iteration: consumes two radicand bits, yields one root bit.
module complex_mag_sqrt_step
  import complex_mag_pkg::*;
#(
  parameter int unsigned OUT_W = CMAG_MAG_W
) (
  input  logic [OUT_W+1:0] rem_i,
  input  logic [OUT_W-1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [OUT_W+1:0] rem_o,
  output logic [OUT_W-1:0] root_o
);

  logic [OUT_W+3:0] ext;
  logic [OUT_W+3:0] trial;
  logic             borrow;
  logic             unused_trial;

  // rem never exceeds 2*root, so ext < 2^(OUT_W+3) and the MSB of trial is its sign.
  always_comb begin
    ext    = {rem_i, bits_i};
    trial  = ext - {2'b00, root_i, 2'b01};
    borrow = trial[OUT_W+3];
    rem_o  = borrow ? ext[OUT_W+1:0] : trial[OUT_W+1:0];
    root_o = {root_i[OUT_W-2:0], ~borrow};
  end

  assign unused_trial = trial[OUT_W+2];

endmodule

// File: rtl/complex_mag_sqrt_stream.sv
// Iterative floor square root with remainder over a valid/ready stream, one root bit per clock.
module complex_mag_sqrt_stream
  import complex_mag_pkg::*;
#(
  parameter int unsigned IN_W = CMAG_SQ_W
) (
  input logic                        clk,
  input logic                        reset_n,
  input logic                        ce,
  complex_mag_sqrt_stream_if.slave   bus
);

  localparam int unsigned OUT_W = IN_W / 2;
  localparam int unsigned CntW  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  if (IN_W % 2 != 0) begin : gen_width_check
    $error("IN_W must be even");
  end

  sqrt_state_t      state_q;
  logic [IN_W-1:0]  rad_q;
  logic [OUT_W+1:0] rem_q;
  logic [OUT_W-1:0] root_q;
  logic [CntW-1:0]  cnt_q;
  logic             last_q;
  logic [OUT_W-1:0] m_data_q;
  logic [OUT_W:0]   m_rem_q;
  logic             m_last_q;
  logic             m_valid_q;

  logic [OUT_W+1:0] step_rem;
  logic [OUT_W-1:0] step_root;

  complex_mag_sqrt_step #(
    .OUT_W (OUT_W)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[IN_W-1:IN_W-2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      m_data_q  <= '0;
      m_rem_q   <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else if (ce) begin
      unique case (state_q)
        StIdle: begin
          if (bus.s_valid) begin
            rad_q   <= bus.s_data;
            last_q  <= bus.s_last;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= CntW'(OUT_W - 1);
            state_q <= StCalc;
          end
        end
        StCalc: begin
          rem_q  <= step_rem;
          root_q <= step_root;
          rad_q  <= {rad_q[IN_W-3:0], 2'b00};
          if (cnt_q == '0) begin
            // Final remainder is bounded by 2*root, so its top bit is always zero here.
            m_data_q  <= step_root;
            m_rem_q   <= step_rem[OUT_W:0];
            m_last_q  <= last_q;
            m_valid_q <= 1'b1;
            state_q   <= StHold;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.s_ready = ce && reset_n && (state_q == StIdle);
  assign bus.m_data  = m_data_q;
  assign bus.m_rem   = m_rem_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_valid = m_valid_q;

endmodule
